// File: rtl/keypad_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and helpers for the matrix-keypad scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Controller states: hunt for a key, confirm it, hand it off, wait for release.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        REPORT   = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Linear key number for a (row, column) position: row-major ordering.
    function automatic int unsigned kp_code(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols = 4);
        return row * cols + col;
    endfunction

    // Bits needed to index n items; never less than one so degenerate
    // single-row/single-column keypads still get a legal vector.
    function automatic int unsigned kp_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl_if
// Purpose  : Key-code valid/ready handshake between the scanner (master) and
//            the downstream key consumer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scan_ctrl_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] key_code;   // row*COLS + col of the debounced key
    logic              key_valid;  // key_code valid, held until accepted
    logic              key_ready;  // consumer accepts when valid && ready
    logic              key_held;   // a debounced key is currently down

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        output key_ready
    );
endinterface : keypad_scan_ctrl_if
`default_nettype wire

// File: rtl/keypad_scan_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick_gen
// Purpose  : Column-dwell divider. Free-running 0..SCAN_TICKS-1 counter that
//            flags the last cycle of every dwell period.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int SCAN_TICKS = 27000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int               CNT_W    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Explicit wrap at SCAN_TICKS-1 so non-power-of-two dwell lengths work.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Dwell counter register; restarts the dwell with column 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule : scan_tick_gen
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : Matrix keypad scanner. Strobes one column at a time, samples the
//            synchronised rows at the end of each dwell, debounces press and
//            release, and emits one key code per press on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 27000,
    parameter int COLS           = 4,
    parameter int ROWS           = 4,
    parameter int DEBOUNCE_SCANS = 4,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ROWS-1:0]     row_in,
    output logic [COLS-1:0]     col_out,
    keypad_scan_ctrl_if.master  key_if
);
    localparam int CODE_W = kp_width(ROWS * COLS);
    localparam int COL_W  = kp_width(COLS);
    localparam int ROW_W  = kp_width(ROWS);
    localparam int DBC_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_SCANS - 1);
    localparam logic [ROWS-1:0]  ROW_IDLE = {ROWS{ACTIVE_LOW}};
    localparam logic [COLS-1:0]  COL_POL  = {COLS{ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Dwell timing
    // ------------------------------------------------------------------
    logic tick;

    scan_tick_gen #(
        .SCAN_TICKS (SCAN_TICKS)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // Row synchroniser and polarity normalisation
    // ------------------------------------------------------------------
    logic [ROWS-1:0] sync1_q;
    logic [ROWS-1:0] sync2_q;
    logic [ROWS-1:0] rows_s;

    // Two-flop synchroniser; cleared to the idle pin level so no phantom key appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= ROW_IDLE;
            sync2_q <= ROW_IDLE;
        end else begin
            sync1_q <= row_in;
            sync2_q <= sync1_q;
        end
    end

    assign rows_s = sync2_q ^ ROW_IDLE;

    // ------------------------------------------------------------------
    // Row decode: exactly one active row is a candidate key; two or more
    // rows in one column is a ghost pattern and is ignored.
    // ------------------------------------------------------------------
    logic             row_any;
    logic             row_multi;
    logic [ROW_W-1:0] row_idx;
    logic             rows_onehot;

    // Priority scan of the rows, also noting whether a second row is active.
    always_comb begin
        row_any   = 1'b0;
        row_multi = 1'b0;
        row_idx   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rows_s[r]) begin
                if (row_any) begin
                    row_multi = 1'b1;
                end
                row_any = 1'b1;
                row_idx = ROW_W'(r);
            end
        end
    end

    assign rows_onehot = row_any & ~row_multi;

    // ------------------------------------------------------------------
    // Scan / debounce / report state machine
    // ------------------------------------------------------------------
    kp_state_t         state_q,   state_d;
    logic [COL_W-1:0]  col_q,     col_d;
    logic [DBC_W-1:0]  dbc_q,     dbc_d;
    logic [ROWS-1:0]   row_oh_q,  row_oh_d;
    logic [ROW_W-1:0]  row_idx_q, row_idx_d;
    logic [CODE_W-1:0] code_q,    code_d;
    logic              valid_q,   valid_d;

    logic [COL_W-1:0]  col_next;
    logic [CODE_W-1:0] code_scan;
    logic [CODE_W-1:0] code_held;

    // Column wrap is explicit so COLS need not be a power of two.
    assign col_next  = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
    // Code from the live decode (single-sample debounce) or from the latched row.
    assign code_scan = CODE_W'(kp_code(int'(row_idx),   int'(col_q), COLS));
    assign code_held = CODE_W'(kp_code(int'(row_idx_q), int'(col_q), COLS));

    // Next-state logic: every decision except the handshake waits for tick.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        dbc_d     = dbc_q;
        row_oh_d  = row_oh_q;
        row_idx_d = row_idx_q;
        code_d    = code_q;
        valid_d   = valid_q;

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (rows_onehot) begin
                        // Candidate key: freeze the column and remember the row.
                        row_oh_d  = rows_s;
                        row_idx_d = row_idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = REPORT;
                            dbc_d   = '0;
                            code_d  = code_scan;
                            valid_d = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                            dbc_d   = DBC_W'(1);
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
            end

            DEBOUNCE: begin
                if (tick) begin
                    if (rows_s == row_oh_q) begin
                        if (dbc_q == DBC_LAST) begin
                            state_d = REPORT;
                            dbc_d   = '0;
                            code_d  = code_held;
                            valid_d = 1'b1;
                        end else begin
                            dbc_d = dbc_q + DBC_W'(1);
                        end
                    end else begin
                        // Bounce or change: give up on this key and move on.
                        state_d = SCAN;
                        dbc_d   = '0;
                        col_d   = col_next;
                    end
                end
            end

            REPORT: begin
                // Release is deliberately not watched here: a key lifted while
                // the consumer stalls is still delivered exactly once.
                if (valid_q && key_if.key_ready) begin
                    state_d = RELEASE;
                    valid_d = 1'b0;
                    dbc_d   = '0;
                end
            end

            RELEASE: begin
                if (tick) begin
                    if (rows_s == '0) begin
                        if (dbc_q == DBC_LAST) begin
                            state_d = SCAN;
                            dbc_d   = '0;
                            col_d   = col_next;
                        end else begin
                            dbc_d = dbc_q + DBC_W'(1);
                        end
                    end else begin
                        dbc_d = '0;
                    end
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State register; reset drops any pending report and restarts at column 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            col_q     <= '0;
            dbc_q     <= '0;
            row_oh_q  <= '0;
            row_idx_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            dbc_q     <= dbc_d;
            row_oh_q  <= row_oh_d;
            row_idx_q <= row_idx_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign col_out          = (COLS'(1) << col_q) ^ COL_POL;
    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;
    assign key_if.key_held  = (state_q == REPORT) || (state_q == RELEASE);

endmodule : keypad_scan_ctrl
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Self-checking bench for keypad_scan_ctrl. A behavioural keypad
//            (pressed-key matrix gated by the driven column) feeds two DUTs,
//            one active-high and one active-low at the pins; expectations come
//            from dwell/debounce timing arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;
    localparam int ST = 4;   // dwell length in clocks
    localparam int NC = 4;
    localparam int NR = 4;
    localparam int DS = 3;   // debounce samples
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ready = 1'b0;
    logic [NR*NC-1:0] pressed = '0;   // bit r*NC+c = key (r,c) is down

    logic [NR-1:0] row_in, row_in_al;
    logic [NC-1:0] col_out, col_out_al;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl_if #(.CODE_W(CW)) kif ();
    keypad_scan_ctrl_if #(.CODE_W(CW)) kif_al ();

    assign kif.key_ready    = ready;
    assign kif_al.key_ready = ready;

    // Physical keypad: a row is active when a pressed key sits in a driven column.
    function automatic logic [NR-1:0] pad_rows(input logic [NR*NC-1:0] p, input logic [NC-1:0] drive);
        logic [NR-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NC; j++)
                if (p[i*NC+j] && drive[j]) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [NC-1:0] oh(input int c);
        logic [NC-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    assign row_in    = pad_rows(pressed, col_out);
    assign row_in_al = ~pad_rows(pressed, ~col_out_al);

    keypad_scan_ctrl #(.SCAN_TICKS(ST), .COLS(NC), .ROWS(NR), .DEBOUNCE_SCANS(DS), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .key_if(kif.master));

    keypad_scan_ctrl #(.SCAN_TICKS(ST), .COLS(NC), .ROWS(NR), .DEBOUNCE_SCANS(DS), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .row_in(row_in_al), .col_out(col_out_al), .key_if(kif_al.master));

    // Wait until column c has just become active (bounded); optionally press key (r,c) first.
    task automatic align(input int c, input int r, input bit do_press, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8 * ST * NC; k++) begin
            @(negedge clk);
            if (col_out != oh(c)) break;
        end
        if (do_press) pressed[r*NC+c] = 1'b1;
        for (int k = 0; k < 8 * ST * NC; k++) begin
            @(negedge clk);
            if (col_out == oh(c)) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL align col%0d: column never driven, col_out=%b", c, col_out);
        end
    endtask

    task automatic test_reset();
        logic [NC-1:0] ec;
        pressed = '0; ready = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 5 * ST; n++) begin
            if (n > 0) @(negedge clk);
            ec = oh((n / ST) % NC);
            vectors++;
            if ({col_out, ~col_out_al, kif.key_valid, kif_al.key_valid, kif.key_held, kif_al.key_held,
                 kif.key_code, kif_al.key_code} !== {ec, ec, 4'b0000, {2*CW{1'b0}}}) begin
                miscompares++;
                $display("FAIL reset_scan n=%0d: col=%b/%b v=%b/%b h=%b/%b code=%0d, need col=%b v=0 h=0 code=0",
                         n, col_out, col_out_al, kif.key_valid, kif_al.key_valid, kif.key_held, kif_al.key_held,
                         kif.key_code, ec);
            end
            if (n == 0) rst_n = 1'b1;
        end
    endtask

    // Press (r,c), let the consumer stall d cycles, release on acceptance.
    task automatic test_press(input int r, input int c, input int d);
        bit ok;
        int n_acc, done, ecode;
        logic [NC-1:0] ec;
        logic ev, eh;
        pressed = '0; ready = (d == 0);
        align(c, r, 1'b1, ok);
        if (!ok) return;
        n_acc = 13 + d;                                  // acceptance edge, relative to column start
        done  = ST * (((n_acc + 3 + ST - 1) / ST) + DS - 1);
        ecode = r * NC + c;
        for (int n = 0; n <= done; n++) begin
            if (n > 0) @(negedge clk);
            ec = (n < done) ? oh(c) : oh((c + 1) % NC);
            ev = (n >= 12) && (n <= 12 + d);
            eh = (n >= 12) && (n < done);
            vectors++;
            if ({col_out, ~col_out_al, kif.key_valid, kif_al.key_valid, kif.key_held, kif_al.key_held}
                !== {ec, ec, ev, ev, eh, eh}) begin
                miscompares++;
                $display("FAIL press k%0d d=%0d n=%0d: col=%b/%b v=%b/%b h=%b/%b, need col=%b v=%b h=%b",
                         ecode, d, n, col_out, col_out_al, kif.key_valid, kif_al.key_valid,
                         kif.key_held, kif_al.key_held, ec, ev, eh);
            end
            if (ev) begin
                vectors++;
                if ({kif.key_code, kif_al.key_code} !== {CW'(ecode), CW'(ecode)}) begin
                    miscompares++;
                    $display("FAIL press_code n=%0d: code=%0d/%0d, need %0d", n, kif.key_code, kif_al.key_code, ecode);
                end
            end
            if (n == 12 + d) ready = 1'b1;
            if (n == 13 + d) begin ready = 1'b0; pressed = '0; end
        end
    endtask

    // Key seen on one sample only: controller must drop it and move on.
    task automatic test_bounce(input int r, input int c);
        bit ok;
        logic [NC-1:0] ec;
        pressed = '0; ready = 1'b1;
        align(c, r, 1'b1, ok);
        if (!ok) return;
        for (int n = 0; n < 3 * ST; n++) begin
            if (n > 0) @(negedge clk);
            ec = (n < 2 * ST) ? oh(c) : oh((c + 1) % NC);
            vectors++;
            if ({col_out, ~col_out_al, kif.key_valid, kif_al.key_valid, kif.key_held, kif_al.key_held}
                !== {ec, ec, 4'b0000}) begin
                miscompares++;
                $display("FAIL bounce r%0d c%0d n=%0d: col=%b/%b v=%b/%b h=%b/%b, need col=%b v=0 h=0",
                         r, c, n, col_out, col_out_al, kif.key_valid, kif_al.key_valid,
                         kif.key_held, kif_al.key_held, ec);
            end
            if (n == ST) pressed = '0;
        end
        ready = 1'b0;
    endtask

    // Two rows in one column: ghost pattern, scanning must carry on unchanged.
    task automatic test_ghost(input int ra, input int rb, input int c);
        bit ok;
        logic [NC-1:0] ec;
        pressed = '0; ready = 1'b1;
        align(c, 0, 1'b0, ok);
        if (!ok) return;
        pressed[ra*NC+c] = 1'b1;
        pressed[rb*NC+c] = 1'b1;
        align(c, 0, 1'b0, ok);
        if (!ok) return;
        for (int n = 0; n < 2 * ST * NC; n++) begin
            if (n > 0) @(negedge clk);
            ec = oh((c + n / ST) % NC);
            vectors++;
            if ({col_out, ~col_out_al, kif.key_valid, kif_al.key_valid, kif.key_held, kif_al.key_held}
                !== {ec, ec, 4'b0000}) begin
                miscompares++;
                $display("FAIL ghost r%0d+r%0d c%0d n=%0d: col=%b/%b v=%b/%b h=%b/%b, need col=%b v=0 h=0",
                         ra, rb, c, n, col_out, col_out_al, kif.key_valid, kif_al.key_valid,
                         kif.key_held, kif_al.key_held, ec);
            end
        end
        pressed = '0; ready = 1'b0;
    endtask

    // Reset while a report is pending: it is abandoned and never re-emitted.
    task automatic test_reset_mid_report(input int r, input int c);
        bit ok;
        logic [NC-1:0] ec;
        pressed = '0; ready = 1'b0;
        align(c, r, 1'b1, ok);
        if (!ok) return;
        repeat (12) @(negedge clk);
        vectors++;
        if ({kif.key_valid, kif_al.key_valid, kif.key_code, kif_al.key_code} !== {2'b11, CW'(r*NC+c), CW'(r*NC+c)}) begin
            miscompares++;
            $display("FAIL pre_reset_report: v=%b/%b code=%0d/%0d, need v=1 code=%0d",
                     kif.key_valid, kif_al.key_valid, kif.key_code, kif_al.key_code, r*NC+c);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        pressed = '0;
        for (int n = 0; n <= 10 * ST; n++) begin
            if (n > 0) @(negedge clk);
            ec = oh((n / ST) % NC);
            vectors++;
            if ({col_out, ~col_out_al, kif.key_valid, kif_al.key_valid, kif.key_held, kif_al.key_held}
                !== {ec, ec, 4'b0000}) begin
                miscompares++;
                $display("FAIL reset_mid_report n=%0d: col=%b/%b v=%b/%b h=%b/%b, need col=%b v=0 h=0",
                         n, col_out, col_out_al, kif.key_valid, kif_al.key_valid,
                         kif.key_held, kif_al.key_held, ec);
            end
            if (n == 0) rst_n = 1'b1;
        end
    endtask

    task automatic test_keypress();
        test_press(2, 1, 0);
        for (int i = 0; i < 3; i++) test_press($urandom_range(NR-1), $urandom_range(NC-1), 0);
    endtask

    task automatic test_backpressure();
        test_press(2, 1, 20);
        for (int i = 0; i < 3; i++) test_press($urandom_range(NR-1), $urandom_range(NC-1), $urandom_range(15, 1));
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) test_press($urandom_range(NR-1), $urandom_range(NC-1), $urandom_range(3));
    endtask

    task automatic test_invalid();
        int ra, rb;
        test_bounce(0, 0);
        test_bounce($urandom_range(NR-1), $urandom_range(NC-1));
        test_ghost(1, 3, 0);
        ra = $urandom_range(NR-1);
        rb = (ra + 1 + $urandom_range(NR-2)) % NR;
        test_ghost(ra, rb, $urandom_range(NC-1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_keypress();
        test_backpressure();
        test_invalid();
        test_back_to_back();
        test_reset_mid_report($urandom_range(NR-1), $urandom_range(NC-1));
        test_keypress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_keypad_scan_ctrl
`default_nettype wire
